// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Segment vectors are {a,b,c,d,e,f,g}, active-low (0 = segment lit).
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    // Phase within a digit slot: anodes off (anti-ghosting gap) or digit lit.
    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-decimal codes (10..15) produce a dark digit.
module bcd_seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup; anything outside 0..9 stays dark.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit display.
// Each digit slot is DIV cycles: BLANK_CYC cycles dark, then the digit lit.
// New values are staged in a pending register and swapped in only at the
// end of the last digit slot so a frame never shows a mix of old and new.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK_CYC  = 16
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic                      lz_en,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]             cnt_reg, cnt_next;
    logic [IW-1:0]             idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0]   disp_reg;
    logic [4*NUM_DIGITS-1:0]   pend_data_reg;
    logic                      pend_valid_reg;
    logic [6:0]                seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]     an_reg, an_next;

    scan_state_t               state;
    logic                      slot_end;
    logic                      boundary;
    logic                      suppress;
    logic [6:0]                dec_seg;
    logic [3:0]                digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     zero_above;

    // Per-digit views of the display register; zero_above[i] means digit i
    // and everything more significant is zero (leading-zero candidate).
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digits[gi]     = disp_reg[4*gi +: 4];
            assign zero_above[gi] = (disp_reg[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate

    assign slot_end   = (cnt_reg == CNT_LAST);
    assign boundary   = slot_end && (idx_reg == IDX_LAST);
    assign frame_done = boundary;
    assign load_ready = !pend_valid_reg;
    assign suppress   = lz_en && (idx_reg != '0) && zero_above[idx_reg];
    assign seg        = seg_reg;
    assign an         = an_reg;

    bcd_seg_dec u_dec (
        .bcd (digits[idx_reg]),
        .seg (dec_seg)
    );

    // Scan phase is a pure function of the position inside the slot.
    always_comb begin
        state = (cnt_reg < CNT_ON) ? SCAN_BLANK : SCAN_ON;
    end

    // Slot counter advance; the digit index steps when a slot ends.
    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    // Next anode/segment pattern for the current phase and digit.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        if (state == SCAN_ON) begin
            an_next[idx_reg] = 1'b0;
            seg_next         = suppress ? SEG_BLANK : dec_seg;
        end
    end

    // Scan position and registered display drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            seg_reg <= SEG_BLANK;
            an_reg  <= '1;
        end else begin
            cnt_reg <= cnt_next;
            idx_reg <= idx_next;
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    // Load handshake and frame-aligned swap of the pending value. Applying
    // and capturing are mutually exclusive (one needs pending set, the
    // other clear), so a capture in the boundary cycle waits a full frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_reg       <= '0;
            pend_data_reg  <= '0;
            pend_valid_reg <= 1'b0;
        end else begin
            if (boundary && pend_valid_reg) begin
                disp_reg       <= pend_data_reg;
                pend_valid_reg <= 1'b0;
            end
            if (load_valid && !pend_valid_reg) begin
                pend_data_reg  <= bcd_in;
                pend_valid_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle gap).
// A time-based reference model predicts every output every cycle; a table of
// hand-decoded values and a few directed sequences cover the corner cases.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int DV    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * DV;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   bcd_in;
    logic          load_valid;
    logic          load_ready;
    logic          lz_en;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          frame_done;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DV), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lz_en      (lz_en),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: cycles since reset, shown value, staged value.
    int          t = 0;
    logic [15:0] mdisp = '0;
    logic [15:0] mpv = '0;
    logic        mpend = 1'b0;
    logic        mvalid = 1'b0;
    logic        last_applied = 1'b0;
    logic [6:0]  dec_tab [16];

    typedef struct {
        logic [15:0] val;
        logic        lz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;
    vec_t tab [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (t=%0d)", name, t);
    endtask

    // What the display should show for scan position pos of a frame.
    task automatic expect_out(input int pos, input logic [15:0] v, input logic lz,
                              output logic [6:0] s, output logic [3:0] a);
        int digit;
        int phase;
        logic [3:0] nib;
        digit = pos / DV;
        phase = pos % DV;
        s = 7'h7F;
        a = 4'hF;
        if (phase >= BC) begin
            a = ~(4'b0001 << digit);
            nib = v[digit*4 +: 4];
            if (lz && digit != 0 && (v >> (4*digit)) == 16'd0)
                s = 7'h7F;
            else
                s = dec_tab[nib];
        end
    endtask

    // One clock: check frame_done before the edge, predict, clock, check.
    task automatic tick();
        logic [6:0]  es;
        logic [3:0]  ea;
        logic        bnd;
        logic        xfer;
        logic        old_pend;
        logic [15:0] bcd_s;
        int          pos;
        pos = t % FRAME;
        bnd = (pos == FRAME - 1);
        if (mvalid) chk("frame_done", {15'd0, frame_done}, {15'd0, bnd});
        expect_out(pos, mdisp, lz_en, es, ea);
        old_pend = mpend;
        xfer = load_valid && !old_pend;
        bcd_s = bcd_in;
        @(posedge clk);
        #1;
        last_applied = 1'b0;
        if (rst) begin
            t = 0; mdisp = '0; mpend = 1'b0; mvalid = 1'b1;
            es = 7'h7F; ea = 4'hF;
        end else begin
            if (bnd && old_pend) begin
                mdisp = mpv; mpend = 1'b0; last_applied = 1'b1;
            end
            if (xfer) begin
                mpv = bcd_s; mpend = 1'b1;
            end
            t++;
        end
        if (mvalid) begin
            chk("seg", {9'd0, seg}, {9'd0, es});
            chk("an", {12'd0, an}, {12'd0, ea});
            chk("load_ready", {15'd0, load_ready}, {15'd0, !mpend});
        end
        @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        int k;
        for (k = 0; k < 2*FRAME; k++) begin
            if (t % FRAME == p) break;
            tick();
        end
        if (k == 2*FRAME) timeout("wait_pos");
    endtask

    task automatic load(input logic [15:0] v);
        int k;
        for (k = 0; k < 4*FRAME; k++) begin
            if (!mpend) break;
            tick();
        end
        if (k == 4*FRAME) timeout("load_wait");
        bcd_in = v;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_apply();
        int k;
        for (k = 0; k < 3*FRAME; k++) begin
            tick();
            if (last_applied) break;
        end
        if (k == 3*FRAME) timeout("wait_apply");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        dec_tab[0] = 7'b0000001; dec_tab[1] = 7'b1001111;
        dec_tab[2] = 7'b0010010; dec_tab[3] = 7'b0000110;
        dec_tab[4] = 7'b1001100; dec_tab[5] = 7'b0100100;
        dec_tab[6] = 7'b0100000; dec_tab[7] = 7'b0001111;
        dec_tab[8] = 7'b0000000; dec_tab[9] = 7'b0000100;
        for (int i = 10; i < 16; i++) dec_tab[i] = 7'b1111111;

        tab[0] = '{16'h1234, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        tab[1] = '{16'h0070, 1'b1, {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}};
        tab[2] = '{16'h00A5, 1'b0, {7'b0000001, 7'b0000001, 7'b1111111, 7'b0100100}};
        tab[3] = '{16'h9086, 1'b1, {7'b0000100, 7'b0000001, 7'b0000000, 7'b0100000}};
        tab[4] = '{16'h0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}};
        tab[5] = '{16'h0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};

        rst = 1'b1; bcd_in = '0; load_valid = 1'b0; lz_en = 1'b0;
        @(negedge clk);

        // Reset held three cycles, then the first lit anode after three edges.
        repeat (3) tick();
        chk("rst_seg", {9'd0, seg}, 16'h007F);
        chk("rst_an", {12'd0, an}, 16'h000F);
        chk("rst_ready", {15'd0, load_ready}, 16'h0001);
        chk("rst_frame_done", {15'd0, frame_done}, 16'h0000);
        rst = 1'b0;
        tick(); tick();
        chk("first_an_gap", {12'd0, an}, 16'h000F);
        tick();
        chk("first_an_on", {12'd0, an}, 16'h000E);

        // Table: load mid-frame, then check each digit's ON phase next frame.
        for (int i = 0; i < 6; i++) begin
            lz_en = tab[i].lz;
            wait_pos(5 + i);
            load(tab[i].val);
            chk("tab_ready_drop", {15'd0, load_ready}, 16'h0000);
            wait_apply();
            for (int j = 1; j <= FRAME; j++) begin
                tick();
                if (j % DV == 5) begin
                    chk("tab_seg", {9'd0, seg}, {9'd0, tab[i].segs[7*(j/DV) +: 7]});
                    chk("tab_an", {12'd0, an}, {12'd0, ~(4'b0001 << (j/DV))});
                end
            end
        end

        // Transfer in the boundary cycle itself: waits one whole frame.
        wait_pos(FRAME - 1);
        bcd_in = 16'h5555;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("coinc_ready", {15'd0, load_ready}, 16'h0000);
        for (int j = 1; j <= FRAME; j++) begin
            tick();
            if (j == 5) chk("coinc_old_digit0", {9'd0, seg}, 16'h0001);
        end
        chk("coinc_applied_ready", {15'd0, load_ready}, 16'h0001);
        repeat (5) tick();
        chk("coinc_new_digit0", {9'd0, seg}, 16'h0024);

        // Second load held while the first is pending.
        lz_en = 1'b0;
        wait_pos(12);
        bcd_in = 16'h1111;
        load_valid = 1'b1;
        tick();
        bcd_in = 16'h2222;
        repeat (3) tick();
        chk("held_ready_low", {15'd0, load_ready}, 16'h0000);
        wait_apply();
        tick();
        load_valid = 1'b0;
        chk("second_accepted", {15'd0, load_ready}, 16'h0000);
        repeat (4) tick();
        chk("first_value_shown", {9'd0, seg}, 16'h004F);
        wait_apply();
        repeat (5) tick();
        chk("second_value_shown", {9'd0, seg}, 16'h0012);

        // Reset during digit 2 ON with a load pending.
        wait_pos(10);
        load(16'h4321);
        wait_pos(2*DV + 4);
        chk("mid_pending", {15'd0, load_ready}, 16'h0000);
        rst = 1'b1;
        tick();
        chk("mid_rst_seg", {9'd0, seg}, 16'h007F);
        chk("mid_rst_an", {12'd0, an}, 16'h000F);
        chk("mid_rst_ready", {15'd0, load_ready}, 16'h0001);
        rst = 1'b0;
        lz_en = 1'b1;
        repeat (3) tick();
        chk("post_rst_d0_an", {12'd0, an}, 16'h000E);
        chk("post_rst_d0_seg", {9'd0, seg}, 16'h0001);
        repeat (8) tick();
        chk("post_rst_d1_an", {12'd0, an}, 16'h000D);
        chk("post_rst_d1_seg", {9'd0, seg}, 16'h007F);

        // Randomized traffic checked every cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                load_valid = ~load_valid;
                for (int n = 0; n < 4; n++)
                    bcd_in[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
            tick();
        end
        load_valid = 1'b0;
        repeat (2*FRAME) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
